// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and GF(2^8) helper for the AES key
// schedule store.
package aes_pkg;

  localparam int KEY_W      = 128;
  localparam int NUM_ROUNDS = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/rcon_gen.sv
// Round-constant sequencer: restarts at 0x01 on load and doubles in
// GF(2^8) on each advance.
module rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       advance,
  output logic [7:0] rcon_byte
);

  logic [7:0] rcon_q;
  logic [7:0] rcon_d;

  always_comb begin
    rcon_d = rcon_q;
    if (load) begin
      rcon_d = RCON_INIT;
    end else if (advance) begin
      rcon_d = xtime(rcon_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcon_q <= RCON_INIT;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign rcon_byte = rcon_q;

endmodule

// File: rtl/key_schedule_store.sv
// Collects the cipher key plus NUM_ROUNDS evolved round keys from the key
// evolution stage and serves them through a registered read port.
module key_schedule_store
  import aes_pkg::*;
#(
  parameter int KEY_W      = aes_pkg::KEY_W,
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             load_key,
  input  logic [KEY_W-1:0] key_in,
  input  logic [KEY_W-1:0] evolved_key_in,
  input  logic             evolved_valid,
  output logic [KEY_W-1:0] round_constant,
  input  logic             rd_req,
  input  logic [3:0]       rd_round,
  output logic [KEY_W-1:0] rd_key,
  output logic             rd_valid,
  output logic             rd_err,
  output logic             busy,
  output logic             schedule_ready,
  output state_t           state_dbg
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             capture;
  logic [7:0]       rcon_byte;

  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [KEY_W-1:0] wr_data;
  logic [KEY_W-1:0] mem_q [NUM_ROUNDS+1];

  logic             rd_ok;
  logic [KEY_W-1:0] rd_key_q, rd_key_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_err_q, rd_err_d;

  // A load in the same cycle always takes priority over a capture.
  assign capture = (state_q == ST_CAPTURE) && clk_en && evolved_valid && !load_key;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (load_key) begin
      state_d = ST_CAPTURE;
      idx_d   = 4'd1;
    end else if (capture) begin
      if (idx_q == LAST_ROUND) begin
        state_d = ST_READY;
      end else begin
        idx_d = idx_q + 4'd1;
      end
    end
    busy_d  = (state_d == ST_CAPTURE);
    ready_d = (state_d == ST_READY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  rcon_gen u_rcon (
    .clk       (clk),
    .rst_n     (reset),
    .load      (load_key),
    .advance   (capture),
    .rcon_byte (rcon_byte)
  );

  assign round_constant = {rcon_byte, {(KEY_W-8){1'b0}}};

  // Single write port: slot 0 on load, slot idx on capture.
  always_comb begin
    wr_en   = load_key || capture;
    wr_addr = load_key ? 4'd0 : idx_q;
    wr_data = load_key ? key_in : evolved_key_in;
  end

  // Storage is deliberately not reset; stale keys stay unreadable until READY.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read handshake: rd_req is a single-cycle request with no back-pressure;
  // exactly one cycle later rd_valid pulses for one cycle with rd_key/rd_err.
  // rd_key holds its last value while rd_valid is low.
  assign rd_ok = (state_q == ST_READY) && (rd_round <= LAST_ROUND) && !load_key;

  always_comb begin
    rd_valid_d = rd_req;
    rd_err_d   = rd_req && !rd_ok;
    rd_key_d   = rd_key_q;
    if (rd_req) begin
      rd_key_d = rd_ok ? mem_q[rd_round] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_key_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_key_q   <= rd_key_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign rd_key         = rd_key_q;
  assign rd_valid       = rd_valid_q;
  assign rd_err         = rd_err_q;
  assign busy           = busy_q;
  assign schedule_ready = ready_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_key_schedule_store.sv
// Directed testbench for key_schedule_store using the FIPS-197 AES-128
// example key schedule.
module tb_key_schedule_store;
  import aes_pkg::*;

  localparam int KW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_en;
  logic          load_key;
  logic [KW-1:0] key_in;
  logic [KW-1:0] evolved_key_in;
  logic          evolved_valid;
  logic [KW-1:0] round_constant;
  logic          rd_req;
  logic [3:0]    rd_round;
  logic [KW-1:0] rd_key;
  logic          rd_valid;
  logic          rd_err;
  logic          busy;
  logic          schedule_ready;
  state_t        state_dbg;

  int checks = 0;
  int errors = 0;

  logic [KW-1:0] rk [11];
  logic [7:0]    exp_rcon [10];

  always #5 clk = ~clk;

  key_schedule_store #(.KEY_W(KW), .NUM_ROUNDS(10)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_en         (clk_en),
    .load_key       (load_key),
    .key_in         (key_in),
    .evolved_key_in (evolved_key_in),
    .evolved_valid  (evolved_valid),
    .round_constant (round_constant),
    .rd_req         (rd_req),
    .rd_round       (rd_round),
    .rd_key         (rd_key),
    .rd_valid       (rd_valid),
    .rd_err         (rd_err),
    .busy           (busy),
    .schedule_ready (schedule_ready),
    .state_dbg      (state_dbg)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    clk_en         = 1'b0;
    load_key       = 1'b0;
    key_in         = '0;
    evolved_key_in = '0;
    evolved_valid  = 1'b0;
    rd_req         = 1'b0;
    rd_round       = 4'd0;
  endtask

  task automatic do_load(input logic [KW-1:0] key);
    load_key = 1'b1;
    key_in   = key;
    step();
    load_key = 1'b0;
  endtask

  task automatic do_capture(input logic [KW-1:0] data);
    clk_en         = 1'b1;
    evolved_valid  = 1'b1;
    evolved_key_in = data;
    step();
    clk_en        = 1'b0;
    evolved_valid = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] r);
    rd_req   = 1'b1;
    rd_round = r;
    step();
    rd_req = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL reset_rd_err got %b exp 0", rd_err); end
    checks++; if (rd_key !== '0) begin errors++; $display("FAIL reset_rd_key got %h exp 0", rd_key); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (schedule_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", schedule_ready); end
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", state_dbg, ST_IDLE); end
    checks++; if (round_constant !== {8'h01, 120'd0}) begin errors++; $display("FAIL reset_rcon got %h exp 01<<120", round_constant); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_fips_schedule();
    do_load(rk[0]);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy got %b exp 1", busy); end
    checks++; if (state_dbg !== ST_CAPTURE) begin errors++; $display("FAIL load_state got %0d exp %0d", state_dbg, ST_CAPTURE); end
    for (int i = 1; i <= 10; i++) begin
      checks++;
      if (round_constant[127:120] !== exp_rcon[i-1]) begin
        errors++; $display("FAIL fips_rcon_%0d got %h exp %h", i, round_constant[127:120], exp_rcon[i-1]);
      end
      do_capture(rk[i]);
    end
    checks++; if (schedule_ready !== 1'b1) begin errors++; $display("FAIL fips_ready got %b exp 1", schedule_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fips_busy got %b exp 0", busy); end
    do_read(4'd1);
    checks++; if (rd_valid !== 1'b1 || rd_err !== 1'b0) begin errors++; $display("FAIL fips_rd1_flags got v=%b e=%b exp v=1 e=0", rd_valid, rd_err); end
    checks++; if (rd_key !== 128'ha0fafe1788542cb123a339392a6c7605) begin errors++; $display("FAIL fips_rd1_key got %h exp a0fafe1788542cb123a339392a6c7605", rd_key); end
    do_read(4'd10);
    checks++; if (rd_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin errors++; $display("FAIL fips_rd10_key got %h exp d014f9a8c9ee2589e13f0cc8b6630ca6", rd_key); end
    do_read(4'd0);
    checks++; if (rd_key !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin errors++; $display("FAIL fips_rd0_key got %h exp 2b7e151628aed2a6abf7158809cf4f3c", rd_key); end
    step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL hold_rd_valid got %b exp 0", rd_valid); end
    checks++; if (rd_key !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin errors++; $display("FAIL hold_rd_key got %h exp 2b7e151628aed2a6abf7158809cf4f3c", rd_key); end
  endtask

  task automatic test_clk_en_strobe();
    int n;
    logic [7:0] exp_b;
    n = 0;
    do_load(rk[0]);
    evolved_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      clk_en         = ((cyc % 4) == 3);
      evolved_key_in = rk[n+1];
      step();
      if (cyc % 4 == 3) n++;
      exp_b = (n < 10) ? exp_rcon[n] : 8'h6c;
      checks++;
      if (round_constant[127:120] !== exp_b) begin
        errors++; $display("FAIL strobe_rcon_cyc%0d got %h exp %h", cyc, round_constant[127:120], exp_b);
      end
    end
    clk_en        = 1'b0;
    evolved_valid = 1'b0;
    checks++; if (schedule_ready !== 1'b1) begin errors++; $display("FAIL strobe_ready got %b exp 1", schedule_ready); end
    do_read(4'd5);
    checks++; if (rd_key !== rk[5] || rd_err !== 1'b0) begin errors++; $display("FAIL strobe_rd5 got %h e=%b exp %h e=0", rd_key, rd_err, rk[5]); end
  endtask

  task automatic test_read_errors();
    do_read(4'd11);
    checks++; if (rd_valid !== 1'b1 || rd_err !== 1'b1 || rd_key !== '0) begin errors++; $display("FAIL rd11 got v=%b e=%b k=%h exp v=1 e=1 k=0", rd_valid, rd_err, rd_key); end
    do_read(4'd15);
    checks++; if (rd_valid !== 1'b1 || rd_err !== 1'b1 || rd_key !== '0) begin errors++; $display("FAIL rd15 got v=%b e=%b k=%h exp v=1 e=1 k=0", rd_valid, rd_err, rd_key); end
    do_read(4'd3);
    checks++; if (rd_key !== rk[3] || rd_err !== 1'b0) begin errors++; $display("FAIL rd3 got %h e=%b exp %h e=0", rd_key, rd_err, rk[3]); end
    do_load(rk[0]);
    do_read(4'd2);
    checks++; if (rd_valid !== 1'b1 || rd_err !== 1'b1 || rd_key !== '0) begin errors++; $display("FAIL rd_capture got v=%b e=%b k=%h exp v=1 e=1 k=0", rd_valid, rd_err, rd_key); end
    evolved_valid  = 1'b1;
    evolved_key_in = rk[1];
    step();
    evolved_valid = 1'b0;
    checks++; if (round_constant[127:120] !== 8'h01) begin errors++; $display("FAIL no_strobe_ignored got %h exp 01", round_constant[127:120]); end
  endtask

  task automatic test_restart();
    for (int i = 1; i <= 5; i++) begin
      do_capture({16{8'(i)}});
    end
    checks++; if (round_constant[127:120] !== 8'h20) begin errors++; $display("FAIL partial_rcon got %h exp 20", round_constant[127:120]); end
    do_load(rk[0]);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %b exp 1", busy); end
    checks++; if (round_constant[127:120] !== 8'h01) begin errors++; $display("FAIL restart_rcon got %h exp 01", round_constant[127:120]); end
    for (int i = 1; i <= 10; i++) begin
      if (i == 6) begin
        checks++; if (schedule_ready !== 1'b0) begin errors++; $display("FAIL restart_early_ready got %b exp 0", schedule_ready); end
      end
      do_capture(rk[i]);
    end
    checks++; if (schedule_ready !== 1'b1) begin errors++; $display("FAIL restart_ready got %b exp 1", schedule_ready); end
    do_read(4'd1);
    checks++; if (rd_key !== rk[1]) begin errors++; $display("FAIL restart_rd1 got %h exp %h", rd_key, rk[1]); end
    do_read(4'd5);
    checks++; if (rd_key !== rk[5]) begin errors++; $display("FAIL restart_rd5 got %h exp %h", rd_key, rk[5]); end
  endtask

  task automatic test_reset_mid_capture();
    do_load(rk[0]);
    for (int i = 1; i <= 3; i++) do_capture(rk[i]);
    reset = 1'b0;
    #1;
    checks++; if (rd_key !== '0) begin errors++; $display("FAIL midrst_rd_key got %h exp 0", rd_key); end
    checks++; if (rd_valid !== 1'b0 || rd_err !== 1'b0) begin errors++; $display("FAIL midrst_flags got v=%b e=%b exp 0 0", rd_valid, rd_err); end
    checks++; if (busy !== 1'b0 || schedule_ready !== 1'b0) begin errors++; $display("FAIL midrst_status got b=%b r=%b exp 0 0", busy, schedule_ready); end
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL midrst_state got %0d exp %0d", state_dbg, ST_IDLE); end
    checks++; if (round_constant[127:120] !== 8'h01) begin errors++; $display("FAIL midrst_rcon got %h exp 01", round_constant[127:120]); end
    step();
    reset = 1'b1;
    step();
    do_read(4'd1);
    checks++; if (rd_valid !== 1'b1 || rd_err !== 1'b1 || rd_key !== '0) begin errors++; $display("FAIL postrst_rd got v=%b e=%b k=%h exp v=1 e=1 k=0", rd_valid, rd_err, rd_key); end
  endtask

  task automatic test_read_load_collision();
    do_load(rk[0]);
    for (int i = 1; i <= 10; i++) do_capture(rk[i]);
    checks++; if (schedule_ready !== 1'b1) begin errors++; $display("FAIL coll_pre_ready got %b exp 1", schedule_ready); end
    rd_req   = 1'b1;
    rd_round = 4'd1;
    load_key = 1'b1;
    key_in   = rk[0];
    step();
    clear_inputs();
    checks++; if (rd_valid !== 1'b1 || rd_err !== 1'b1 || rd_key !== '0) begin errors++; $display("FAIL coll_rd got v=%b e=%b k=%h exp v=1 e=1 k=0", rd_valid, rd_err, rd_key); end
    checks++; if (schedule_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL coll_status got r=%b b=%b exp r=0 b=1", schedule_ready, busy); end
  endtask

  initial begin
    rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    exp_rcon[0] = 8'h01; exp_rcon[1] = 8'h02; exp_rcon[2] = 8'h04; exp_rcon[3] = 8'h08;
    exp_rcon[4] = 8'h10; exp_rcon[5] = 8'h20; exp_rcon[6] = 8'h40; exp_rcon[7] = 8'h80;
    exp_rcon[8] = 8'h1b; exp_rcon[9] = 8'h36;

    test_reset();
    test_fips_schedule();
    test_clk_en_strobe();
    test_read_errors();
    test_restart();
    test_reset_mid_capture();
    test_read_load_collision();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
